// File: rtl/sys_io_pkg.sv
// Shared constants, register-map decode and types for the sys_io_bridge register file.
package sys_io_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_OUT_BASE = 8'h00;
  localparam addr_t ADDR_CAP_BASE = 8'h10;
  localparam addr_t ADDR_TRIGGER  = 8'h20;
  localparam addr_t ADDR_STATUS   = 8'h21;
  localparam addr_t ADDR_IRQ_EN   = 8'h22;
  localparam addr_t ADDR_OVERFLOW = 8'h23;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_OUT,
    REG_CAP,
    REG_TRIGGER,
    REG_STATUS,
    REG_IRQ_EN,
    REG_OVERFLOW
  } reg_sel_e;

  // Classifies a word address into its register region; REG_NONE means unmapped.
  function automatic reg_sel_e decode_addr(addr_t a, int n_in, int n_out);
    int off_out;
    int off_cap;
    off_out = int'(a) - int'(ADDR_OUT_BASE);
    off_cap = int'(a) - int'(ADDR_CAP_BASE);
    if (off_out >= 0 && off_out < n_in)  return REG_OUT;
    if (off_cap >= 0 && off_cap < n_out) return REG_CAP;
    case (a)
      ADDR_TRIGGER:  return REG_TRIGGER;
      ADDR_STATUS:   return REG_STATUS;
      ADDR_IRQ_EN:   return REG_IRQ_EN;
      ADDR_OVERFLOW: return REG_OVERFLOW;
      default:       return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sys_io_capture.sv
// One result channel from the reconfigurable logic: captured word, STATUS and
// OVERFLOW flags, and the acknowledge pulse issued when software clears STATUS.
module sys_io_capture
  import sys_io_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_decouple,
  input  logic  i_capture,
  input  word_t i_data,
  input  logic  i_clr_status,
  input  logic  i_clr_overflow,
  output word_t o_word,
  output logic  o_status,
  output logic  o_overflow,
  output logic  o_ack
);

  word_t r_word;
  logic  r_status;
  logic  r_overflow;
  logic  r_ack;

  logic  w_do_capture;
  logic  w_do_clear;

  assign w_do_capture = i_capture & ~i_decouple;
  // A capture in the same cycle as the clear wins, so no acknowledge is sent.
  assign w_do_clear   = i_clr_status & r_status & ~w_do_capture;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the word register is reset because its zero value is readable by software.
      r_word     <= '0;
      r_status   <= 1'b0;
      r_overflow <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= w_do_clear & ~i_decouple;

      if (w_do_capture) begin
        r_word   <= i_data;
        r_status <= 1'b1;
      end else if (w_do_clear) begin
        r_status <= 1'b0;
      end

      if (w_do_capture && r_status && !i_clr_status) begin
        r_overflow <= 1'b1;
      end else if (i_clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_word     = r_word;
  assign o_status   = r_status;
  assign o_overflow = r_overflow;
  assign o_ack      = r_ack & ~i_decouple;

endmodule

// File: rtl/sys_io_bridge.sv
// Host register bridge to a partially-reconfigurable region: output words with
// trigger pulses, captured result words with STATUS/OVERFLOW and an interrupt.
module sys_io_bridge
  import sys_io_pkg::*;
#(
  parameter int number_inputs  = 7,
  parameter int number_outputs = 3
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             DECOUPLE,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [WORD_W-1:0]                wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [WORD_W-1:0]                rd_data,
  output logic                             rd_valid,
  output logic [number_inputs*WORD_W-1:0]  data_out,
  output logic [number_inputs-1:0]         intr_out,
  input  logic [number_outputs*WORD_W-1:0] data_in,
  input  logic [number_outputs-1:0]        intr_in,
  output logic [number_inputs-1:0]         intr_ack,
  output logic                             irq
);

  logic [number_inputs-1:0][WORD_W-1:0] r_out_words;
  logic [number_outputs-1:0]            r_irq_en;
  logic [number_inputs-1:0]             r_intr_out;
  logic                                 r_irq;
  word_t                                r_rd_data;
  logic                                 r_rd_valid;

  reg_sel_e                             w_wr_sel;
  reg_sel_e                             w_rd_sel;
  word_t                                w_rd_mux;
  word_t                                w_cap_word [number_outputs];
  logic [number_outputs-1:0]            w_status;
  logic [number_outputs-1:0]            w_overflow;
  logic [number_outputs-1:0]            w_ack;

  assign w_wr_sel = wr_en ? decode_addr(wr_addr, number_inputs, number_outputs) : REG_NONE;
  assign w_rd_sel = decode_addr(rd_addr, number_inputs, number_outputs);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_words <= '0;
      r_irq_en    <= '0;
      r_intr_out  <= '0;
      r_irq       <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      if (w_wr_sel == REG_OUT) begin
        for (int i = 0; i < number_inputs; i++) begin
          if (wr_addr == ADDR_OUT_BASE + addr_t'(i)) r_out_words[i] <= wr_data;
        end
      end
      if (w_wr_sel == REG_IRQ_EN) r_irq_en <= wr_data[number_outputs-1:0];

      // Triggers seen during decouple are dropped, never replayed later.
      r_intr_out <= (w_wr_sel == REG_TRIGGER && !DECOUPLE) ? wr_data[number_inputs-1:0] : '0;
      r_irq      <= |(w_status & r_irq_en);
      r_rd_valid <= rd_en;
      r_rd_data  <= rd_en ? w_rd_mux : '0;
    end
  end

  // NOTE: w_rd_mux gets its default first so no path through the case infers a latch.
  always_comb begin
    w_rd_mux = '0;
    case (w_rd_sel)
      REG_OUT: begin
        for (int i = 0; i < number_inputs; i++) begin
          if (rd_addr == ADDR_OUT_BASE + addr_t'(i)) w_rd_mux = r_out_words[i];
        end
      end
      REG_CAP: begin
        for (int j = 0; j < number_outputs; j++) begin
          if (rd_addr == ADDR_CAP_BASE + addr_t'(j)) w_rd_mux = w_cap_word[j];
        end
      end
      REG_STATUS:   w_rd_mux[number_outputs-1:0] = w_status;
      REG_IRQ_EN:   w_rd_mux[number_outputs-1:0] = r_irq_en;
      REG_OVERFLOW: w_rd_mux[number_outputs-1:0] = w_overflow;
      default:      w_rd_mux = '0;
    endcase
  end

  for (genvar j = 0; j < number_outputs; j++) begin : g_cap
    sys_io_capture u_capture (
      .i_clk          (CLK),
      .i_rst          (RESET),
      .i_decouple     (DECOUPLE),
      .i_capture      (intr_in[j]),
      .i_data         (data_in[j*WORD_W +: WORD_W]),
      .i_clr_status   ((w_wr_sel == REG_STATUS) & wr_data[j]),
      .i_clr_overflow ((w_wr_sel == REG_OVERFLOW) & wr_data[j]),
      .o_word         (w_cap_word[j]),
      .o_status       (w_status[j]),
      .o_overflow     (w_overflow[j]),
      .o_ack          (w_ack[j])
    );
  end

  for (genvar k = 0; k < number_inputs; k++) begin : g_ack
    if (k < number_outputs) begin : g_live
      assign intr_ack[k] = w_ack[k];
    end else begin : g_tied
      assign intr_ack[k] = 1'b0;
    end
  end

  assign data_out = r_out_words;
  assign intr_out = r_intr_out & {number_inputs{~DECOUPLE}};
  assign irq      = r_irq;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_sys_io_bridge.sv
// Directed and randomized bench for sys_io_bridge against a register-map reference model.
module tb_sys_io_bridge;

  localparam int NI = 7;
  localparam int NO = 3;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            DECOUPLE;
  logic            wr_en;
  logic [7:0]      wr_addr;
  logic [31:0]     wr_data;
  logic            rd_en;
  logic [7:0]      rd_addr;
  logic [31:0]     rd_data;
  logic            rd_valid;
  logic [NI*32-1:0] data_out;
  logic [NI-1:0]   intr_out;
  logic [NO*32-1:0] data_in;
  logic [NO-1:0]   intr_in;
  logic [NI-1:0]   intr_ack;
  logic            irq;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_out [NI];
  logic [31:0] m_cap [NO];
  logic [NO-1:0] m_status, m_ovf, m_irq_en;
  logic [NI-1:0] e_intr_out, e_ack;
  logic          e_irq, e_rd_valid;
  logic [31:0]   e_rd_data;

  always #5 CLK = ~CLK;

  sys_io_bridge #(.number_inputs(NI), .number_outputs(NO)) dut (
    .CLK(CLK), .RESET(RESET), .DECOUPLE(DECOUPLE),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .data_out(data_out), .intr_out(intr_out),
    .data_in(data_in), .intr_in(intr_in),
    .intr_ack(intr_ack), .irq(irq)
  );

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(logic [7:0] a);
    int ai = int'(a);
    if (ai < NI) return m_out[ai];
    if (ai >= 16 && ai < 16 + NO) return m_cap[ai-16];
    if (ai == 33) return 32'(m_status);
    if (ai == 34) return 32'(m_irq_en);
    if (ai == 35) return 32'(m_ovf);
    return 32'h0;
  endfunction

  // Advance one clock: predict from the current inputs, then compare all outputs.
  task automatic tick();
    logic [NO-1:0] cap, clr, ovf_set;
    logic [NI*32-1:0] exp_pack;
    if (RESET) begin
      for (int i = 0; i < NI; i++) m_out[i] = 32'h0;
      for (int j = 0; j < NO; j++) m_cap[j] = 32'h0;
      m_status = '0; m_ovf = '0; m_irq_en = '0;
      e_intr_out = '0; e_ack = '0; e_irq = 1'b0;
      e_rd_valid = 1'b0; e_rd_data = 32'h0;
    end else begin
      e_rd_valid = rd_en;
      e_rd_data  = model_read(rd_addr);
      e_irq      = |(m_status & m_irq_en);
      e_intr_out = (wr_en && wr_addr == 8'h20 && !DECOUPLE) ? wr_data[NI-1:0] : '0;
      cap        = DECOUPLE ? '0 : intr_in;
      clr        = (wr_en && wr_addr == 8'h21) ? wr_data[NO-1:0] : '0;
      e_ack      = '0;
      e_ack[NO-1:0] = DECOUPLE ? '0 : (clr & m_status & ~cap);
      ovf_set    = cap & m_status & ~clr;
      if (wr_en) begin
        if (int'(wr_addr) < NI) m_out[int'(wr_addr)] = wr_data;
        if (wr_addr == 8'h22) m_irq_en = wr_data[NO-1:0];
        if (wr_addr == 8'h23) m_ovf = m_ovf & ~wr_data[NO-1:0];
      end
      m_ovf    = m_ovf | ovf_set;
      m_status = (m_status & ~clr) | cap;
      for (int j = 0; j < NO; j++) if (cap[j]) m_cap[j] = data_in[j*32 +: 32];
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NI; i++) exp_pack[i*32 +: 32] = m_out[i];
    check("data_out", data_out, exp_pack);
    check("intr_out", intr_out, e_intr_out);
    check("intr_ack", intr_ack, e_ack);
    check("irq", irq, e_irq);
    check("rd_valid", rd_valid, e_rd_valid);
    if (e_rd_valid || RESET) check("rd_data", rd_data, RESET ? 32'h0 : e_rd_data);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; intr_in = '0;
  endtask

  task automatic write(logic [7:0] a, logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read(logic [7:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] addr_pool [18];
    addr_pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'hFF};

    RESET = 1'b1; DECOUPLE = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; data_in = '0;
    idle();
    tick();
    tick();
    check("reset_data_out", data_out, 0);
    check("reset_irq", irq, 0);
    RESET = 1'b0;
    tick();

    // Output word write and a single-cycle trigger pulse.
    write(8'h02, 32'hDEADBEEF);
    write(8'h20, 32'h0000_0004);
    check("t029_pulse", intr_out, 7'h04);
    check("t029_word", data_out[95:64], 32'hDEADBEEF);
    tick();
    check("t029_pulse_gone", intr_out, 7'h00);

    // Capture on channel 1 with its interrupt enabled, then W1C.
    write(8'h22, 32'h2);
    data_in[63:32] = 32'h12345678;
    intr_in = 3'b010;
    tick();
    intr_in = '0;
    tick();
    check("t030_irq_set", irq, 1'b1);
    read(8'h11);
    check("t030_word", rd_data, 32'h12345678);
    read(8'h21);
    check("t030_status", rd_data, 32'h2);
    write(8'h21, 32'h2);
    check("t030_ack", intr_ack, 7'h02);
    tick();
    check("t030_irq_clr", irq, 1'b0);
    check("t030_ack_gone", intr_ack, 7'h00);

    // Two captures on channel 0 without a clear.
    data_in[31:0] = 32'hAAAA0001;
    intr_in = 3'b001;
    tick();
    data_in[31:0] = 32'hBBBB0002;
    tick();
    intr_in = '0;
    read(8'h23);
    check("t031_overflow", rd_data, 32'h1);
    read(8'h10);
    check("t031_word", rd_data, 32'hBBBB0002);

    // Capture on channel 2 while STATUS[2] is being cleared: set wins, no ack.
    data_in[95:64] = 32'hC0DE0001;
    intr_in = 3'b100;
    tick();
    data_in[95:64] = 32'hC0DE0002;
    write(8'h21, 32'h4);
    intr_in = '0;
    check("t032_no_ack", intr_ack, 7'h00);
    read(8'h21);
    check("t032_status", rd_data[2], 1'b1);
    read(8'h23);
    check("t032_ovf", rd_data, 32'h1);
    write(8'h21, 32'h7);
    write(8'h23, 32'h7);

    // Decouple discards triggers and captures; nothing appears on release.
    DECOUPLE = 1'b1;
    intr_in = 3'b111;
    write(8'h20, 32'h7F);
    check("t033_no_pulse", intr_out, 7'h00);
    intr_in = '0;
    read(8'h21);
    check("t033_status", rd_data, 32'h0);
    DECOUPLE = 1'b0;
    tick();
    check("t033_no_late_pulse", intr_out, 7'h00);

    // Reset in the middle of a trigger and a read.
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'h7F; rd_en = 1'b1; rd_addr = 8'h02;
    tick();
    RESET = 1'b1;
    tick();
    check("t034_intr_out", intr_out, 7'h00);
    check("t034_rd_valid", rd_valid, 1'b0);
    RESET = 1'b0;
    idle();
    read(8'h30);
    check("t034_unmapped_valid", rd_valid, 1'b1);
    check("t034_unmapped_data", rd_data, 32'h0);

    // Randomized traffic with the model checking every cycle.
    for (int n = 0; n < 600; n++) begin
      DECOUPLE = ($urandom_range(0, 9) == 0);
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = addr_pool[$urandom_range(0, 17)];
      wr_data  = $urandom();
      if (wr_addr == 8'h21 || wr_addr == 8'h23) wr_data = {$urandom_range(0, 1) ? 24'h0 : 24'hFFFFFF, 8'($urandom())};
      rd_en    = ($urandom_range(0, 1) == 1);
      rd_addr  = addr_pool[$urandom_range(0, 17)];
      for (int j = 0; j < NO; j++) data_in[j*32 +: 32] = $urandom();
      intr_in  = NO'($urandom()) & NO'($urandom());
      RESET    = ($urandom_range(0, 99) == 0);
      tick();
    end
    RESET = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
